uart_stream_ctrl: RTL and testbench

Bus-master sequencer that drives the UART register block on behalf of the system. On a start command it configures the UART, then streams a byte buffer from memory into the UART TX data register. Before each byte it polls the UART state register for TX-FIFO-full. It sits beside the core LSU on the peripheral bus and offloads console/log output from software.

---
 rtl/uart_stream_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_uart_stream_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module : uart_stream_ctrl
// Brief  : Configures the UART, then streams a memory byte buffer into the TX
//          data register, polling TX-FIFO-full before each byte.
//          Define UART_STREAM_CRLF_EN to send every LF as CR+LF.
// Rev    : 1.0  initial release
// ============================================================================
module uart_stream_ctrl #(
    parameter logic [31:0] UART_BASE  = 32'h8000_1000,
    parameter int          LEN_W      = 16,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [6:0]       cfg_params_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       err_code_o,
    output logic             mem_req_o,
    output logic [31:0]      mem_addr_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i,
    input  logic             mem_err_i,
    output logic             uart_req_o,
    output logic             uart_we_o,
    output logic [3:0]       uart_be_o,
    output logic [31:0]      uart_addr_o,
    output logic [31:0]      uart_wdata_o,
    input  logic             uart_gnt_i,
    input  logic [31:0]      uart_rdata_i,
    input  logic             uart_err_i
);
    localparam int                  c_pcnt_w    = $clog2(POLL_LIMIT + 1);
    localparam logic [c_pcnt_w-1:0] c_poll_max  = c_pcnt_w'(POLL_LIMIT);
    localparam logic [31:0]         c_reg_data  = UART_BASE + 32'h04;
    localparam logic [31:0]         c_reg_state = UART_BASE + 32'h08;
    localparam logic [31:0]         c_reg_ctrl  = UART_BASE + 32'h0C;
    localparam logic [31:0]         c_reg_param = UART_BASE + 32'h10;
`ifdef UART_STREAM_CRLF_EN
    localparam logic                c_crlf      = 1'b1;
`else
    localparam logic                c_crlf      = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CFG_PARAM = 4'd1,
        S_CFG_EN    = 4'd2,
        S_FETCH     = 4'd3,
        S_FETCH_RSP = 4'd4,
        S_POLL      = 4'd5,
        S_POLL_RSP  = 4'd6,
        S_WRITE     = 4'd7,
        S_WRITE_RSP = 4'd8,
        S_FINISH    = 4'd9
    } state_t;

    state_t              r_state;
    logic [31:0]         r_addr;
    logic [31:0]         r_buf;
    logic [LEN_W-1:0]    r_remaining;
    logic [c_pcnt_w-1:0] r_poll_cnt;
    logic                r_rsp_wait;
    logic                r_is_cr;
    logic                r_cr_done;
    logic [1:0]          r_err;
    logic                r_busy;
    logic                r_done;
    logic                r_mem_req;
    logic [31:0]         r_mem_addr;
    logic                r_uart_req;
    logic                r_uart_we;
    logic [31:0]         r_uart_addr;
    logic [31:0]         r_uart_wdata;

    logic [7:0]          w_byte;
    logic [31:0]         w_word;
    logic [31:0]         w_addr_next;
    logic [c_pcnt_w-1:0] w_poll_next;
    logic                w_send_cr;
    logic                w_unused;

    assign w_word      = r_buf >> {r_addr[1:0], 3'b000};
    assign w_byte      = w_word[7:0];
    assign w_addr_next = r_addr + 32'd1;
    assign w_poll_next = r_poll_cnt + c_pcnt_w'(1);
    // The CR is inserted once per LF; r_cr_done marks it as already sent.
    assign w_send_cr   = c_crlf && (w_byte == 8'h0A) && !r_cr_done;
    assign w_unused    = ^{uart_rdata_i[31:2], uart_rdata_i[0]};

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_code_o   = r_err;
    assign mem_req_o    = r_mem_req;
    assign mem_addr_o   = r_mem_addr;
    assign uart_req_o   = r_uart_req;
    assign uart_we_o    = r_uart_we;
    assign uart_be_o    = 4'hF;
    assign uart_addr_o  = r_uart_addr;
    assign uart_wdata_o = r_uart_wdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_buf        <= '0;
            r_remaining  <= '0;
            r_poll_cnt   <= '0;
            r_rsp_wait   <= 1'b0;
            r_is_cr      <= 1'b0;
            r_cr_done    <= 1'b0;
            r_err        <= 2'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_uart_req   <= 1'b0;
            r_uart_we    <= 1'b0;
            r_uart_addr  <= '0;
            r_uart_wdata <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_addr      <= src_addr_i;
                        r_remaining <= len_i;
                        r_err       <= 2'd0;
                        r_poll_cnt  <= '0;
                        r_cr_done   <= 1'b0;
                        r_rsp_wait  <= 1'b0;
                        if (len_i == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_busy       <= 1'b1;
                            r_uart_req   <= 1'b1;
                            r_uart_we    <= 1'b1;
                            r_uart_addr  <= c_reg_param;
                            r_uart_wdata <= {25'b0, cfg_params_i};
                            r_state      <= S_CFG_PARAM;
                        end
                    end
                end
                // Config writes share one grant/response sequence.
                S_CFG_PARAM, S_CFG_EN: begin
                    if (!r_rsp_wait) begin
                        if (uart_gnt_i) begin
                            r_uart_req <= 1'b0;
                            r_rsp_wait <= 1'b1;
                        end
                    end else begin
                        r_rsp_wait <= 1'b0;
                        if (uart_err_i) begin
                            r_err   <= 2'd3;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else if (r_state == S_CFG_PARAM) begin
                            r_uart_req   <= 1'b1;
                            r_uart_addr  <= c_reg_ctrl;
                            r_uart_wdata <= 32'h3;
                            r_state      <= S_CFG_EN;
                        end else begin
                            r_uart_we  <= 1'b0;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {r_addr[31:2], 2'b00};
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (mem_gnt_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_FETCH_RSP;
                    end
                end
                S_FETCH_RSP: begin
                    if (mem_rvalid_i) begin
                        if (mem_err_i) begin
                            r_err   <= 2'd1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_buf       <= mem_rdata_i;
                            r_uart_req  <= 1'b1;
                            r_uart_we   <= 1'b0;
                            r_uart_addr <= c_reg_state;
                            r_state     <= S_POLL;
                        end
                    end
                end
                S_POLL: begin
                    if (uart_gnt_i) begin
                        r_uart_req <= 1'b0;
                        r_state    <= S_POLL_RSP;
                    end
                end
                S_POLL_RSP: begin
                    if (uart_rdata_i[1]) begin
                        if (w_poll_next == c_poll_max) begin
                            r_err   <= 2'd2;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_poll_cnt <= w_poll_next;
                            r_uart_req <= 1'b1;
                            r_state    <= S_POLL;
                        end
                    end else begin
                        r_poll_cnt   <= '0;
                        r_uart_req   <= 1'b1;
                        r_uart_we    <= 1'b1;
                        r_uart_addr  <= c_reg_data;
                        r_uart_wdata <= {24'b0, (w_send_cr ? 8'h0D : w_byte)};
                        r_is_cr      <= w_send_cr;
                        r_state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (uart_gnt_i) begin
                        r_uart_req <= 1'b0;
                        r_state    <= S_WRITE_RSP;
                    end
                end
                S_WRITE_RSP: begin
                    if (uart_err_i || r_is_cr) begin
                        // Failed writes retry the same character; a sent CR
                        // is followed by its LF.
                        r_cr_done   <= r_cr_done | (r_is_cr & ~uart_err_i);
                        r_uart_req  <= 1'b1;
                        r_uart_we   <= 1'b0;
                        r_uart_addr <= c_reg_state;
                        r_state     <= S_POLL;
                    end else begin
                        r_cr_done   <= 1'b0;
                        r_addr      <= w_addr_next;
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else if (w_addr_next[1:0] == 2'b00) begin
                            r_uart_we  <= 1'b0;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {w_addr_next[31:2], 2'b00};
                            r_state    <= S_FETCH;
                        end else begin
                            r_uart_req  <= 1'b1;
                            r_uart_we   <= 1'b0;
                            r_uart_addr <= c_reg_state;
                            r_state     <= S_POLL;
                        end
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_stream_ctrl
// Brief  : Bus slaves log traffic; a byte-level model predicts data and fetches.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_stream_ctrl;
    localparam logic [31:0] c_base       = 32'h8000_1000;
    localparam int          c_poll_limit = 8;
    localparam logic [31:0] c_a_data     = c_base + 32'h04;
    localparam logic [31:0] c_a_state    = c_base + 32'h08;
    localparam logic [31:0] c_a_en       = c_base + 32'h0C;
    localparam logic [31:0] c_a_param    = c_base + 32'h10;

    logic        clk_i = 1'b0;
    logic        rst_ni, start_i, busy_o, done_o;
    logic [31:0] src_addr_i;
    logic [15:0] len_i;
    logic [6:0]  cfg_params_i;
    logic [1:0]  err_code_o;
    logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_addr_o, mem_rdata_i;
    logic        uart_req_o, uart_we_o, uart_gnt_i, uart_err_i;
    logic [3:0]  uart_be_o;
    logic [31:0] uart_addr_o, uart_wdata_o, uart_rdata_i;

    uart_stream_ctrl #(.UART_BASE(c_base), .LEN_W(16), .POLL_LIMIT(c_poll_limit)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .src_addr_i(src_addr_i),
        .len_i(len_i), .cfg_params_i(cfg_params_i), .busy_o(busy_o), .done_o(done_o),
        .err_code_o(err_code_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .mem_err_i(mem_err_i), .uart_req_o(uart_req_o), .uart_we_o(uart_we_o),
        .uart_be_o(uart_be_o), .uart_addr_o(uart_addr_o), .uart_wdata_o(uart_wdata_o),
        .uart_gnt_i(uart_gnt_i), .uart_rdata_i(uart_rdata_i), .uart_err_i(uart_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic [31:0] mem [0:1023];
    txn_t        ulog[$];
    logic [31:0] fetch_q[$];
    logic [7:0]  data_q[$];
    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_fetch[$];
    int n_done = 0, n_polls = 0, n_viol = 0;
    int base_done, base_polls, base_viol, base_ulog, base_fetch, base_data;
    int n_checks = 0, n_errors = 0;
    int xfer_id = 0, poll_first = 0;
    bit poll_rand = 0, poll_stuck = 0, werr_en = 0, cfg_err_en = 0, fault_en = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[11:2]] >> {a[1:0], 3'b000};
        return w[7:0];
    endfunction

    // Reference: one UART data write per source byte (LF preceded by CR when
    // the CRLF option is built in), one fetch per word touched.
    task automatic build_model(input logic [31:0] src, input int len);
        logic [31:0] a;
        logic [7:0]  b;
        exp_bytes.delete();
        exp_fetch.delete();
        for (int i = 0; i < len; i++) begin
            a = src + 32'(i);
            if (i == 0 || a[1:0] == 2'b00) exp_fetch.push_back({a[31:2], 2'b00});
            b = mem_byte(a);
`ifdef UART_STREAM_CRLF_EN
            if (b == 8'h0A) exp_bytes.push_back(8'h0D);
`endif
            exp_bytes.push_back(b);
        end
    endtask

    // Memory and UART register slaves, plus done-pulse counting.
    initial begin
        int          seen_id = 0, full_left = 0, m_delay = 0;
        bit          m_pend = 0, u_pend = 0, u_err = 0, poll_free = 0;
        logic [31:0] m_addr = '0, u_rdata = '0;
        txn_t        t;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; mem_err_i = 0;
        uart_gnt_i = 0; uart_rdata_i = '0; uart_err_i = 0;
        forever begin
            @(negedge clk_i);
            if (done_o) n_done++;
            if (xfer_id != seen_id) begin
                seen_id = xfer_id; full_left = poll_first; poll_free = 0;
            end
            mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = '0;
            uart_rdata_i = '0; uart_err_i = 0; mem_gnt_i = 0; uart_gnt_i = 0;
            if (!rst_ni) begin
                m_pend = 0; u_pend = 0; poll_free = 0;
            end else begin
                if (m_pend) begin
                    if (m_delay == 0) begin
                        mem_rvalid_i = 1; mem_rdata_i = mem[m_addr[11:2]];
                        mem_err_i = fault_en; m_pend = 0;
                    end else m_delay--;
                end
                if (u_pend) begin
                    uart_rdata_i = u_rdata; uart_err_i = u_err; u_pend = 0;
                end
                if (mem_req_o && !m_pend && $urandom_range(0, 2) != 0) begin
                    mem_gnt_i = 1; m_pend = 1; m_delay = $urandom_range(0, 2);
                    m_addr = mem_addr_o; fetch_q.push_back(mem_addr_o);
                end
                if (uart_req_o && $urandom_range(0, 2) != 0) begin
                    uart_gnt_i = 1; u_pend = 1; u_err = 0; u_rdata = '0;
                    t.we = uart_we_o; t.addr = uart_addr_o; t.wdata = uart_wdata_o;
                    ulog.push_back(t);
                    if (uart_be_o !== 4'hF) n_viol++;
                    if (!uart_we_o) begin
                        if (uart_addr_o == c_a_state) begin
                            n_polls++;
                            u_rdata = $urandom & ~32'h2;
                            if (poll_stuck || full_left > 0) begin
                                u_rdata = u_rdata | 32'h2;
                                if (full_left > 0) full_left--;
                            end else begin
                                poll_free = 1;
                                full_left = poll_rand ? $urandom_range(0, 3) : 0;
                            end
                        end else n_viol++;
                    end else if (uart_addr_o == c_a_data) begin
                        if (!poll_free || uart_wdata_o[31:8] != 24'h0) n_viol++;
                        poll_free = 0;
                        if (werr_en && $urandom_range(0, 5) == 0) u_err = 1;
                        else data_q.push_back(uart_wdata_o[7:0]);
                    end else if (uart_addr_o == c_a_param) begin
                        u_err = cfg_err_en;
                    end else if (uart_addr_o != c_a_en) n_viol++;
                end
            end
        end
    end

    task automatic pulse_start(input logic [31:0] src, input int len, input logic [6:0] prm);
        @(negedge clk_i);
        base_done = n_done; base_polls = n_polls; base_viol = n_viol;
        base_ulog = ulog.size(); base_fetch = fetch_q.size(); base_data = data_q.size();
        xfer_id++;
        start_i = 1; src_addr_i = src; len_i = 16'(len); cfg_params_i = prm;
        @(negedge clk_i);
        start_i = 0;
    endtask

    task automatic run_xfer(input logic [31:0] src, input int len, input logic [6:0] prm,
                            input int extra_start, output int lat, output logic busy0);
        bit to = 1;
        pulse_start(src, len, prm);
        busy0 = busy_o;
        lat = -1;
        for (int c = 0; c < 6000; c++) begin
            if (done_o) begin to = 0; lat = c; break; end
            if (c == extra_start) begin
                start_i = 1; src_addr_i = src ^ 32'h40; len_i = 16'd1; cfg_params_i = 7'h15;
            end else start_i = 0;
            @(negedge clk_i);
        end
        start_i = 0;
        check("xfer.timeout", to, 0);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic check_result(input string tag, input logic [1:0] exp_err, input bit exp_data);
        int nd, nf;
        nd = data_q.size() - base_data;
        nf = fetch_q.size() - base_fetch;
        check({tag, ".done"}, 64'(n_done - base_done), 1);
        check({tag, ".err"}, err_code_o, exp_err);
        check({tag, ".busy"}, busy_o, 0);
        check({tag, ".viol"}, 64'(n_viol - base_viol), 0);
        if (!exp_data) begin
            check({tag, ".ndata"}, 64'(nd), 0);
        end else begin
            check({tag, ".ndata"}, 64'(nd), 64'(exp_bytes.size()));
            check({tag, ".nfetch"}, 64'(nf), 64'(exp_fetch.size()));
            for (int i = 0; i < nd && i < exp_bytes.size(); i++)
                check({tag, ".byte"}, data_q[base_data + i], exp_bytes[i]);
            for (int i = 0; i < nf && i < exp_fetch.size(); i++)
                check({tag, ".faddr"}, fetch_q[base_fetch + i], exp_fetch[i]);
        end
    endtask

    // Exact UART transaction order for a stall-free, error-free transfer.
    task automatic check_ulog(input string tag, input logic [6:0] prm);
        int n;
        n = ulog.size() - base_ulog;
        check({tag, ".ntxn"}, 64'(n), 64'(2 + 2 * exp_bytes.size()));
        if (n == 2 + 2 * exp_bytes.size()) begin
            check({tag, ".param"}, {ulog[base_ulog].we, ulog[base_ulog].addr, ulog[base_ulog].wdata},
                  {1'b1, c_a_param, 25'b0, prm});
            check({tag, ".en"}, {ulog[base_ulog+1].we, ulog[base_ulog+1].addr, ulog[base_ulog+1].wdata},
                  {1'b1, c_a_en, 32'h3});
            for (int i = 0; i < exp_bytes.size(); i++) begin
                check({tag, ".poll"}, {ulog[base_ulog+2+2*i].we, ulog[base_ulog+2+2*i].addr},
                      {1'b0, c_a_state});
                check({tag, ".wr"}, {ulog[base_ulog+3+2*i].we, ulog[base_ulog+3+2*i].addr,
                      ulog[base_ulog+3+2*i].wdata}, {1'b1, c_a_data, 24'b0, exp_bytes[i]});
            end
        end
    endtask

    initial begin
        int          lat;
        logic        busy0;
        logic [31:0] w, src;
        int          len;
        bit          found;
        rst_ni = 0; start_i = 0; src_addr_i = '0; len_i = '0; cfg_params_i = '0;
        for (int i = 0; i < 1024; i++) begin
            for (int b = 0; b < 4; b++)
                w[8*b +: 8] = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
            mem[i] = w;
        end
        repeat (3) @(negedge clk_i);
        check("rst.busy", busy_o, 0);
        check("rst.done", done_o, 0);
        check("rst.err", err_code_o, 0);
        check("rst.mem_req", mem_req_o, 0);
        check("rst.mem_addr", mem_addr_o, 0);
        check("rst.uart_req", uart_req_o, 0);
        check("rst.uart_we", uart_we_o, 0);
        check("rst.uart_addr", uart_addr_o, 0);
        check("rst.uart_wdata", uart_wdata_o, 0);
        check("rst.uart_be", uart_be_o, 4'hF);
        rst_ni = 1;

        mem[32'h100 >> 2] = 32'h4443_4241;
        build_model(32'h100, 3);
        run_xfer(32'h100, 3, 7'h62, -1, lat, busy0);
        check("basic.busy0", busy0, 1);
        check_result("basic", 2'd0, 1);
        check_ulog("basic", 7'h62);

        build_model(32'h103, 2);
        run_xfer(32'h103, 2, 7'h11, -1, lat, busy0);
        check_result("unal", 2'd0, 1);
        check_ulog("unal", 7'h11);

        poll_first = 5;
        build_model(32'h200, 1);
        run_xfer(32'h200, 1, 7'h01, -1, lat, busy0);
        check_result("poll5", 2'd0, 1);
        check("poll5.npolls", 64'(n_polls - base_polls), 6);
        poll_first = 0; poll_stuck = 1;
        run_xfer(32'h204, 3, 7'h02, -1, lat, busy0);
        check_result("stuck", 2'd2, 0);
        check("stuck.npolls", 64'(n_polls - base_polls), c_poll_limit);
        poll_stuck = 0;

        fault_en = 1;
        run_xfer(32'h300, 4, 7'h03, -1, lat, busy0);
        check_result("memerr", 2'd1, 0);
        check("memerr.npolls", 64'(n_polls - base_polls), 0);
        fault_en = 0; cfg_err_en = 1;
        run_xfer(32'h300, 4, 7'h04, -1, lat, busy0);
        check_result("cfgerr", 2'd3, 0);
        check("cfgerr.nfetch", 64'(fetch_q.size() - base_fetch), 0);
        cfg_err_en = 0;
        run_xfer(32'h300, 0, 7'h05, -1, lat, busy0);
        check_result("len0", 2'd0, 0);
        check("len0.lat", 64'(lat), 0);
        check("len0.ntxn", 64'(ulog.size() - base_ulog + fetch_q.size() - base_fetch), 0);

        mem[32'h340 >> 2] = 32'h0000_0A41;
        build_model(32'h340, 2);
        run_xfer(32'h340, 2, 7'h06, -1, lat, busy0);
        check_result("crlf", 2'd0, 1);
        check_ulog("crlf", 7'h06);

        build_model(32'hFFFF_FFFE, 5);
        run_xfer(32'hFFFF_FFFE, 5, 7'h07, -1, lat, busy0);
        check_result("wrap", 2'd0, 1);

        build_model(32'h181, 6);
        run_xfer(32'h181, 6, 7'h08, 5, lat, busy0);
        check_result("busystart", 2'd0, 1);
        check_ulog("busystart", 7'h08);

        poll_rand = 1; werr_en = 1;
        for (int k = 0; k < 12; k++) begin
            src = $urandom_range(0, 4095);
            len = $urandom_range(1, 24);
            build_model(src, len);
            run_xfer(src, len, 7'($urandom), -1, lat, busy0);
            check_result("rand", 2'd0, 1);
        end
        poll_rand = 0; werr_en = 0;

        pulse_start(32'h400, 8, 7'h09);
        found = 0;
        for (int c = 0; c < 600 && !found; c++) begin
            @(negedge clk_i);
            if (uart_req_o && uart_we_o && uart_addr_o == c_a_data) found = 1;
        end
        check("rstmid.found", found, 1);
        rst_ni = 0;
        #1;
        check("rstmid.uart_req", uart_req_o, 0);
        check("rstmid.busy", busy_o, 0);
        check("rstmid.err", err_code_o, 0);
        check("rstmid.mem_req", mem_req_o, 0);
        @(posedge clk_i);
        #1;
        check("rstmid.uart_req2", uart_req_o, 0);
        @(negedge clk_i);
        rst_ni = 1;
        build_model(32'h402, 5);
        run_xfer(32'h402, 5, 7'h0A, -1, lat, busy0);
        check_result("after_rst", 2'd0, 1);
        check_ulog("after_rst", 7'h0A);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end
endmodule
`default_nettype wire
